key_schedule_seq: RTL
=====================

KEY_SCHEDULE_SEQ -- requirements
Module: key_schedule_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: clk  in  1  sole clock, rising edge.
REQ-003 Port: rst_n  in  1  asynchronous active-low reset.
REQ-004 Port: start  in  1  one-cycle request to begin an expansion.
REQ-005 Port: key_len  in  2  key size: 0=AES-128, 1=AES-192, 2=AES-256, 3=reserved.
REQ-006 Port: key_in  in  256  cipher key, left-justified; word w0 = key_in[255:224]; unused low bits ignored.
REQ-007 Port: rk  out  128  current round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
REQ-008 Port: rk_idx  out  4  round index r of rk.
REQ-009 Port: rk_valid  out  1  rk/rk_idx valid.
REQ-010 Port: rk_ready  in  1  consumer accepts rk when rk_valid && rk_ready.
REQ-011 Port: busy  out  1  high from start acceptance until the final round key is accepted.

Function
REQ-012 Nk/Nr SHALL be 4/10, 6/12, 8/14 for key_len 0/1/2; key_len 3 SHALL be treated as 0.
REQ-013 States: IDLE, GEN, HOLD; IDLE->GEN on start, which latches key_in and key_len.
REQ-014 start SHALL be ignored when busy=1.
REQ-015 GEN SHALL produce one 32-bit word per cycle: w[i]=key word i for i<Nk; otherwise w[i]=w[i-Nk]^temp.
REQ-016 temp: SubWord(RotWord(w[i-1])) with rcon XORed into byte [31:24] when i mod Nk==0; SubWord(w[i-1]) when Nk=8 and i mod 8==4; else w[i-1].
REQ-017 RotWord SHALL be {w[23:0], w[31:24]}; rcon SHALL start at 8'h01 and advance by GF(2^8) xtime (poly 8'h1b) after each use.
REQ-018 An 8-deep word history register SHALL supply w[i-1] and w[i-Nk].
REQ-019 After each 4th word GEN->HOLD with rk_valid=1; first rk_valid SHALL be 4 cycles after start acceptance.
REQ-020 rk, rk_idx, rk_valid SHALL hold stable in HOLD while rk_ready=0.
REQ-021 On handshake in HOLD: if rk_idx==Nr -> IDLE and busy=0 next cycle; else -> GEN with rk_idx+1.
REQ-022 rk_ready while not rk_valid SHALL have no effect; total keys emitted SHALL be Nr+1 (11/13/15).

Reset
REQ-023 Reset SHALL force IDLE and rk=0, rk_idx=0, rk_valid=0, busy=0, history and rcon cleared, at any time including mid-expansion.
REQ-024 After reset deassertion the first start SHALL begin a fresh expansion with no residue from the aborted one.

Configuration
REQ-025 Macro KEYSCHED_WIDE_KEY_EN: defined -> AES-192/256 supported per REQ-012.
REQ-026 Without KEYSCHED_WIDE_KEY_EN: key_len SHALL be ignored, Nk=4/Nr=10 always, history depth 4, REQ-016 Nk=8 clause absent.

Structure
REQ-027 Shared package SHALL hold the key_len encoding, Nk/Nr constants, rcon initial value 8'h01 and reduction poly 8'h1b.
REQ-028 Sub-module: s_box (existing 8-bit S-box), instantiated 4 times for SubWord.

Verification
REQ-029 AES-128 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> rk_idx 1 = a0fafe1788542cb123a339392a6c7605, rk_idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, exactly 11 keys.
REQ-030 AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> rk_idx 12 = e98ba06f448c773c8ecc720401002202.
REQ-031 AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> rk_idx 14 = fe4890d1e6188d0b046df344706c631e.
REQ-032 rk_ready low 7 cycles at rk_idx 3 -> rk/rk_idx stable throughout; sequence identical to REQ-029.
REQ-033 start pulsed while busy, then rst_n low at rk_idx 5 -> second start ignored; all outputs 0 next cycle; new start yields REQ-029 sequence.

Source files
------------

// File: rtl/key_schedule_seq_pkg.sv
// Shared definitions for the AES key schedule: key-size encoding, Nk/Nr, rcon seed and GF(2^8) helper.
package key_schedule_seq_pkg;

  typedef enum logic [1:0] {
    KEY_128  = 2'd0,
    KEY_192  = 2'd1,
    KEY_256  = 2'd2,
    KEY_RSVD = 2'd3
  } key_len_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int NK_128 = 4;
  localparam int NK_192 = 6;
  localparam int NK_256 = 8;
  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1b;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/s_box.sv
// AES forward S-box, one byte, purely combinational (zero latency, no flow control).
module s_box (
  input  logic [7:0] a,
  output logic [7:0] s
);

  // Entry 0x00 sits in the top byte so the index is simply the inverted input.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign s = SBOX_TABLE[{~a, 3'b111} -: 8];

endmodule

// File: rtl/key_schedule_seq.sv
// AES key expansion, one word per cycle; first rk_valid 4 cycles after start, rk held stable until rk_ready.
// KEYSCHED_WIDE_KEY_EN adds AES-192/256 (8-word history); without it key_len is ignored and AES-128 is used.
module key_schedule_seq
  import key_schedule_seq_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  output logic [127:0] rk,
  output logic [3:0]   rk_idx,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy
);

`ifdef KEYSCHED_WIDE_KEY_EN
  localparam int HIST = 8;
`else
  localparam int HIST = 4;
`endif

  state_e                state, state_nxt;
  logic [255:0]          key_q;
  logic [HIST-1:0][31:0] hist;
  logic [7:0]            rcon;
  logic [2:0]            pos;
  logic                  init_done;
  logic [1:0]            wcnt;
  logic [2:0]            nk_last;
  logic [3:0]            nr;
  logic [31:0]           far_word, sub_in, sub_out, temp, w_new;
  logic                  load, gen_en, adv_round;

`ifdef KEYSCHED_WIDE_KEY_EN
  key_len_e klen_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    klen_q <= KEY_128;
    else if (load) klen_q <= key_len_e'(key_len);
  end

  // Reserved encoding falls through to AES-128.
  always_comb begin
    nk_last  = 3'(NK_128 - 1);
    nr       = 4'(NR_128);
    far_word = hist[3];
    case (klen_q)
      KEY_192: begin nk_last = 3'(NK_192 - 1); nr = 4'(NR_192); far_word = hist[5]; end
      KEY_256: begin nk_last = 3'(NK_256 - 1); nr = 4'(NR_256); far_word = hist[7]; end
      default: ;
    endcase
  end
`else
  logic unused_key_len;
  assign unused_key_len = ^key_len;
  assign nk_last  = 3'(NK_128 - 1);
  assign nr       = 4'(NR_128);
  assign far_word = hist[3];
`endif

  // hist[0] is w[i-1]; SubWord input is rotated only at the start of each Nk group.
  always_comb begin
    sub_in = (pos == 3'd0) ? {hist[0][23:0], hist[0][31:24]} : hist[0];
    temp   = hist[0];
    if (pos == 3'd0) temp = sub_out ^ {rcon, 24'h0};
`ifdef KEYSCHED_WIDE_KEY_EN
    else if (nk_last == 3'd7 && pos == 3'd4) temp = sub_out;
`endif
    w_new = init_done ? (far_word ^ temp) : key_q[255:224];
  end

  for (genvar b = 0; b < 4; b++) begin : g_sub
    s_box u_s_box (
      .a (sub_in[8*b +: 8]),
      .s (sub_out[8*b +: 8])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    gen_en    = 1'b0;
    adv_round = 1'b0;
    rk_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = GEN;
        end
      end
      GEN: begin
        gen_en = 1'b1;
        if (wcnt == 2'd3) state_nxt = HOLD;
      end
      HOLD: begin
        rk_valid = 1'b1;
        if (rk_ready) begin
          if (rk_idx == nr) begin
            state_nxt = IDLE;
          end else begin
            adv_round = 1'b1;
            state_nxt = GEN;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q     <= '0;
      hist      <= '0;
      rcon      <= '0;
      pos       <= '0;
      init_done <= 1'b0;
      wcnt      <= '0;
      rk        <= '0;
      rk_idx    <= '0;
    end else if (load) begin
      key_q     <= key_in;
      hist      <= '0;
      rcon      <= RCON_INIT;
      pos       <= '0;
      init_done <= 1'b0;
      wcnt      <= '0;
      rk_idx    <= '0;
    end else if (gen_en) begin
      key_q <= {key_q[223:0], 32'h0};
      hist  <= {hist[HIST-2:0], w_new};
      rk    <= {rk[95:0], w_new};
      wcnt  <= wcnt + 2'd1;
      if (init_done && pos == 3'd0) rcon <= xtime(rcon);
      if (pos == nk_last) begin
        pos       <= '0;
        init_done <= 1'b1;
      end else begin
        pos <= pos + 3'd1;
      end
    end else if (adv_round) begin
      rk_idx <= rk_idx + 4'd1;
    end
  end

endmodule
